// File: rtl/div_pkg.sv
// Shared widths, FSM state type and sign helper for the iterative restoring divider.
package div_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DREG_W = 64;
  localparam int unsigned CNT_W  = 6;

  localparam logic [CNT_W-1:0] DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [REG_W-1:0] neg_if(input logic en, input logic [REG_W-1:0] v);
    return en ? ('0 - v) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// EX-stage to divider request/response bundle; original signal names kept for drop-in use.
interface div_if;
  import div_pkg::*;

  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle, result {rem, quo}.
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);

  div_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [REG_W-1:0]  r_rem,   w_rem_nxt;
  logic [REG_W-1:0]  r_quo,   w_quo_nxt;
  logic [REG_W-1:0]  r_dvsr,  w_dvsr_nxt;
  logic              r_qsign, w_qsign_nxt;
  logic              r_rsign, w_rsign_nxt;
  logic [DREG_W-1:0] r_result, w_result_nxt;
  logic              r_ready,  w_ready_nxt;

  logic [REG_W:0]    w_partial;
  logic [REG_W:0]    w_diff;

  // r_quo starts as the dividend magnitude: its MSB feeds the partial remainder
  // while quotient bits shift in at the LSB.
  assign w_partial = {r_rem, r_quo[REG_W-1]};
  assign w_diff    = w_partial - {1'b0, r_dvsr};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvsr_nxt   = r_dvsr;
    w_qsign_nxt  = r_qsign;
    w_rsign_nxt  = r_rsign;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    unique case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        if (bus.start_i && !bus.annul_i) begin
          w_rsign_nxt = bus.signed_div_i & bus.opdata1_i[REG_W-1];
          w_qsign_nxt = bus.signed_div_i & (bus.opdata1_i[REG_W-1] ^ bus.opdata2_i[REG_W-1]);
          w_quo_nxt   = neg_if(bus.signed_div_i & bus.opdata1_i[REG_W-1], bus.opdata1_i);
          w_dvsr_nxt  = neg_if(bus.signed_div_i & bus.opdata2_i[REG_W-1], bus.opdata2_i);
          w_rem_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end

      DIV_BYZERO: begin
        if (bus.annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = '0;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end else begin
          w_state_nxt  = DIV_END;
          w_ready_nxt  = 1'b1;
          w_result_nxt = '0;
        end
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = '0;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end else if (r_cnt == DIV_STEPS) begin
          w_state_nxt  = DIV_END;
          w_ready_nxt  = 1'b1;
          w_result_nxt = {neg_if(r_rsign, r_rem), neg_if(r_qsign, r_quo)};
          w_cnt_nxt    = '0;
        end else begin
          w_quo_nxt = {r_quo[REG_W-2:0], ~w_diff[REG_W]};
          w_rem_nxt = w_diff[REG_W] ? w_partial[REG_W-1:0] : w_diff[REG_W-1:0];
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DIV_END: begin
        if (bus.annul_i || !bus.start_i) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = '0;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvsr   <= w_dvsr_nxt;
      r_qsign  <= w_qsign_nxt;
      r_rsign  <= w_rsign_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected {rem, quo} and latency, a monitor checks on ready_o rise.
module tb_div;

  typedef struct {
    logic [63:0] res;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t sbq[$];

  div_if bus();

  div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ready_o && !prev) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready: got result %h with no request outstanding", bus.result_o);
        end else begin
          e = sbq.pop_front();
          check("result", bus.result_o, e.res);
          check("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
      end
      prev = bus.ready_o;
    end
  end

  // Called at a negedge; accept happens on the next posedge.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input int unsigned lat, input bit push);
    exp_t e;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    if (push) begin
      e.res = res;
      e.lat = lat;
      e.t0  = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic finish_op(input int unsigned hold, input logic [63:0] res);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (bus.ready_o) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ready_o still 0 after 80 cycles, expected 1");
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    for (int unsigned i = 0; i < hold; i++) begin
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      @(negedge clk);
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, res);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check("release_ready", 64'(bus.ready_o), 64'd0);
    check("release_result", bus.result_o, 64'd0);
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [31:0] q, input int unsigned lat);
    issue(sgn, a, b, {r, q}, lat, 1'b1);
    finish_op(0, {r, q});
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic signed [31:0] sa, sb;
    logic sgn;

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);

    issue(1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b1);
    finish_op(3, 64'd0);

    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 34);
    run(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2, 34);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
    run(1'b1, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 2);

    // start with annul held in FREE must not be accepted
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd20;
    bus.opdata2_i    = 32'd6;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    repeat (3) @(negedge clk);
    check("start_annul_ready", 64'(bus.ready_o), 64'd0);
    issue(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 34, 1'b1);
    finish_op(0, {32'd2, 32'd3});

    // annul mid-division, then a new request accepted on the following edge
    issue(1'b0, 32'h1234_5678, 32'h11, 64'd0, 0, 1'b0);
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    check("annul_result", bus.result_o, 64'd0);
    issue(1'b0, 32'h10, 32'h3, {32'd1, 32'd5}, 34, 1'b1);
    finish_op(0, {32'd1, 32'd5});

    // asynchronous reset between edges in the middle of a division
    issue(1'b0, 32'd1000, 32'd7, 64'd0, 0, 1'b0);
    repeat (21) @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("async_rst_ready", 64'(bus.ready_o), 64'd0);
    check("async_rst_result", bus.result_o, 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 34);

    for (int k = 0; k < 8; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      if (sgn) begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
      run(sgn, a, b, r, q, 34);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drain", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
